// File: rtl/fifo_packer_pkg.sv
// Shared definitions for the FIFO read packer: PACK limits, lane index type
// and the per-lane parity helper.
package fifo_packer_pkg;

  localparam int PACK_MIN     = 2;
  localparam int PACK_MAX     = 16;
  // Widest lane the parity helper accepts; narrower lanes are zero-extended,
  // which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 64;

  typedef logic [$clog2(PACK_MAX)-1:0] lane_idx_t;

  function automatic logic lane_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port plus packed valid/ready stream of the read packer.
// Optional macro: FIFO_PACKER_PARITY_EN adds m_parity.
interface fifo_read_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
);

  logic                       rd_en;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_empty;
  logic                       m_valid;
  logic                       m_ready;
  logic [DATA_WIDTH*PACK-1:0] m_data;
`ifdef FIFO_PACKER_PARITY_EN
  logic [PACK-1:0]            m_parity;

  modport master (
    output rd_en, m_valid, m_data, m_parity,
    input  rd_data, rd_empty, m_ready
  );

  modport slave (
    input  rd_en, m_valid, m_data, m_parity,
    output rd_data, rd_empty, m_ready
  );
`else
  modport master (
    output rd_en, m_valid, m_data,
    input  rd_data, rd_empty, m_ready
  );

  modport slave (
    input  rd_en, m_valid, m_data,
    output rd_data, rd_empty, m_ready
  );
`endif

endinterface

// File: rtl/packer_out_reg.sv
// Valid/ready output register: loads a completed word, holds it stable until
// the sink takes it. A load in the same cycle as a transfer wins and keeps
// valid high.
module packer_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Output word and valid flag; data only changes on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Pops FIFO entries and packs PACK of them into one word, first entry in
// lane 0. Pops are withheld so a completing word always finds the output
// register free.
// Optional macro: FIFO_PACKER_PARITY_EN adds registered per-lane even parity.
module fifo_read_packer
  import fifo_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_read_packer_if.master bus
);

  localparam int        WORD_W    = DATA_WIDTH * PACK;
  localparam lane_idx_t LAST_LANE = lane_idx_t'(PACK - 1);
`ifdef FIFO_PACKER_PARITY_EN
  localparam int        OUT_W     = WORD_W + PACK;
`else
  localparam int        OUT_W     = WORD_W;
`endif

  if (PACK < PACK_MIN || PACK > PACK_MAX) begin : g_bad_pack
    $error("fifo_read_packer: PACK out of range 2..16");
  end

  typedef logic [PACK-1:0][DATA_WIDTH-1:0] lanes_t;

  lanes_t     lanes;
  lanes_t     word_next;
  lane_idx_t  count;
  lane_idx_t  next_lane;
  logic       inflight;
  logic       complete;
  logic       out_busy;
  logic [OUT_W-1:0] out_next;
  logic [OUT_W-1:0] out_data;

  // Land the returning entry into its lane and work out the post-landing lane.
  always_comb begin
    word_next = lanes;
    for (int i = 0; i < PACK; i++) begin
      if (inflight && count == lane_idx_t'(i)) begin
        word_next[i] = bus.rd_data;
      end
    end
    complete = inflight && (count == LAST_LANE);
    if (!inflight) begin
      next_lane = count;
    end else if (complete) begin
      next_lane = '0;
    end else begin
      next_lane = lane_idx_t'(count + lane_idx_t'(1));
    end
  end

  // Issue: the pop that would finish a word is held back while the output
  // register is occupied and stalled. rst gates rd_en so no entry is popped
  // into a reset and lost.
  always_comb begin
    out_busy   = bus.m_valid && !bus.m_ready;
    bus.rd_en  = !rst && !bus.rd_empty &&
                 ((next_lane != LAST_LANE) || (!out_busy && !complete));
  end

  // Assembly lanes, lane counter and in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes    <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      lanes    <= word_next;
      count    <= next_lane;
      inflight <= bus.rd_en;
    end
  end

`ifdef FIFO_PACKER_PARITY_EN
  if (DATA_WIDTH > PARITY_MAX_W) begin : g_bad_width
    $error("fifo_read_packer: DATA_WIDTH too wide for parity helper");
  end

  logic [PACK-1:0] par_next;

  // Per-lane parity of the word about to be loaded.
  always_comb begin
    par_next = '0;
    for (int i = 0; i < PACK; i++) begin
      par_next[i] = lane_parity(PARITY_MAX_W'(word_next[i]));
    end
    out_next = {par_next, word_next};
  end

  assign bus.m_parity = out_data[OUT_W-1:WORD_W];
`else
  // Output register payload is just the packed word.
  always_comb begin
    out_next = word_next;
  end
`endif

  packer_out_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (complete),
    .load_data (out_next),
    .ready     (bus.m_ready),
    .valid     (bus.m_valid),
    .data      (out_data)
  );

  assign bus.m_data = out_data[WORD_W-1:0];

  a_no_overwrite : assert property (@(posedge clk) disable iff (rst)
    complete |-> (!bus.m_valid || bus.m_ready));

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer with a queue-modelled FIFO.
// Optional macro: FIFO_PACKER_PARITY_EN enables the parity checks.
module tb_fifo_read_packer;

  logic clk = 1'b0;
  logic rst;

  fifo_read_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus ();

  fifo_read_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  int          cyc;
  int          pops;
  int          empty_pops;
  logic [63:0] rd_hist;
  logic [63:0] val_hist;
  logic        s_rd_en;
  logic        s_valid;
  logic [31:0] s_data;
`ifdef FIFO_PACKER_PARITY_EN
  logic [3:0]  s_par;
  logic [3:0]  got_par[$];
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input int k);
    if (k < got_q.size()) return 64'(got_q[k]);
    return 64'hBAD0_BAD0_BAD0;
  endfunction

  function automatic int cyc_at(input int k);
    if (k < got_cyc.size()) return got_cyc[k];
    return -1;
  endfunction

  task automatic clear_log();
    cyc        = 0;
    pops       = 0;
    empty_pops = 0;
    rd_hist    = '0;
    val_hist   = '0;
    got_q.delete();
    got_cyc.delete();
`ifdef FIFO_PACKER_PARITY_EN
    got_par.delete();
`endif
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    bus.rd_empty = 1'b0;
  endtask

  // One clock: sample outputs at the falling edge, then model the FIFO read
  // port just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_rd_en = bus.rd_en;
    s_valid = bus.m_valid;
    s_data  = bus.m_data;
`ifdef FIFO_PACKER_PARITY_EN
    s_par   = bus.m_parity;
`endif
    if (s_rd_en) pops++;
    if (s_rd_en && bus.rd_empty) empty_pops++;
    if (cyc < 64) begin
      rd_hist[cyc]  = s_rd_en;
      val_hist[cyc] = s_valid;
    end
    if (s_valid && bus.m_ready) begin
      got_q.push_back(s_data);
      got_cyc.push_back(cyc);
`ifdef FIFO_PACKER_PARITY_EN
      got_par.push_back(s_par);
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
    if (s_rd_en && fifo_q.size() > 0) bus.rd_data = fifo_q.pop_front();
    else                              bus.rd_data = 8'hEE;
    bus.rd_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst          = 1'b1;
    bus.m_ready  = 1'b0;
    bus.rd_empty = 1'b1;
    bus.rd_data  = 8'h00;
    clear_log();

    // Reset state, FIFO pre-filled while reset is held
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    bus.m_ready = 1'b1;
    run(2);
    chk("rst_rd_en",   64'(s_rd_en), 64'd0);
    chk("rst_m_valid", 64'(s_valid), 64'd0);
    chk("rst_m_data",  64'(s_data),  64'd0);
`ifdef FIFO_PACKER_PARITY_EN
    chk("rst_m_parity", 64'(s_par), 64'd0);
`endif

    // First word after reset: rd_en cycles 0..3, m_valid only at cycle 5
    rst = 1'b0;
    clear_log();
    run(8);
    chk("t1_rd_hist",  rd_hist[7:0],  64'h0F);
    chk("t1_val_hist", val_hist[7:0], 64'h20);
    chk("t1_word",     word_at(0),    64'h4433_2211);

    // Twelve entries, sink always ready: three words, no rd_en gaps
    clear_log();
    for (int i = 1; i <= 12; i++) push(8'(i));
    run(20);
    chk("t2_rd_hist", rd_hist[19:0], 64'h0_0FFF);
    chk("t2_nwords",  64'(got_q.size()), 64'd3);
    chk("t2_word0",   word_at(0), 64'h0403_0201);
    chk("t2_word1",   word_at(1), 64'h0807_0605);
    chk("t2_word2",   word_at(2), 64'h0C0B_0A09);
    chk("t2_cyc0",    64'(cyc_at(0)), 64'd5);
    chk("t2_cyc1",    64'(cyc_at(1)), 64'd9);
    chk("t2_cyc2",    64'(cyc_at(2)), 64'd13);

    // Backpressure: one word held, three more pops, then rd_en stays low
    bus.m_ready = 1'b0;
    clear_log();
    for (int i = 1; i <= 8; i++) push(8'(i));
    run(12);
    chk("t3_pops",    64'(pops), 64'd7);
    chk("t3_rd_hist", rd_hist[11:0], 64'h07F);
    chk("t3_hold_v",  64'(s_valid), 64'd1);
    chk("t3_hold_d",  64'(s_data),  64'h0403_0201);
    bus.m_ready = 1'b1;
    clear_log();
    cycle();
    bus.m_ready = 1'b0;
    run(2);
    chk("t3_xfer",     word_at(0), 64'h0403_0201);
    chk("t3_xfer_pop", rd_hist[2:0],  64'b001);
    chk("t3_val_hist", val_hist[2:0], 64'b101);
    chk("t3_next_d",   64'(s_data), 64'h0807_0605);
    bus.m_ready = 1'b1;
    cycle();
    chk("t3_next_xfer", word_at(1), 64'h0807_0605);

    // FIFO runs dry mid-word, resumes ten cycles later at the same lane
    clear_log();
    push(8'hAA); push(8'hBB);
    run(12);
    push(8'hCC); push(8'hDD);
    run(8);
    chk("t4_nwords",   64'(got_q.size()), 64'd1);
    chk("t4_word",     word_at(0), 64'hDDCC_BBAA);
    chk("t4_val_cnt",  64'($countones(val_hist)), 64'd1);
    chk("t4_rd_hist",  rd_hist[19:0], 64'h0_3003);
    chk("t4_empty_rd", 64'(empty_pops), 64'd0);

    // Reset after the third pop of a word; old lanes must not leak
    clear_log();
    push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65);
    run(3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t5_valid", 64'(s_valid), 64'd0);
    push(8'h71); push(8'h72); push(8'h73);
    run(10);
    chk("t5_nwords", 64'(got_q.size()), 64'd1);
    chk("t5_word",   word_at(0), 64'h7271_6564);

`ifdef FIFO_PACKER_PARITY_EN
    // Parity: lanes 00,01,03,07 give 4'b1010
    rst = 1'b1;
    fifo_q.delete();
    bus.rd_empty = 1'b1;
    run(2);
    rst = 1'b0;
    clear_log();
    push(8'h00); push(8'h01); push(8'h03); push(8'h07);
    run(8);
    chk("t6_word", word_at(0), 64'h0703_0100);
    chk("t6_par",  (got_par.size() > 0) ? 64'(got_par[0]) : 64'hBAD, 64'b1010);
`endif

    chk("all_empty_rd", 64'(empty_pops), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
